// File: rtl/reg_seq_pkg.sv
// Shared types and register-select encodings for the register-file sequencer.
package reg_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWReq,
        StWWait,
        StIReq,
        StIWait,
        StCompute,
        StRReq,
        StCheck,
        StDone
    } state_e;

    localparam logic [1:0] SEL_IMG_ADDR    = 2'd0;
    localparam logic [1:0] SEL_IMG_CNT     = 2'd1;
    localparam logic [1:0] SEL_RSLT_ADDR   = 2'd2;
    localparam logic [1:0] SEL_WEIGHT_ADDR = 2'd3;

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Host config, register-file, memory-port and compute handshake bundle for reg_seq_ctrl.
// master = the sequencer, slave = its surroundings (register file, memory, compute engine, host).
interface reg_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 28
);
    logic              cfg_valid;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              start;
    logic [ADDR_W-1:0] num_imgs;
    logic              busy;
    logic              done;
    logic [1:0]        wr_reg_sel;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_databus;
    logic [1:0]        rd_reg_sel;
    logic [31:0]       reg_out;
    logic              inc_img_addr;
    logic              inc_img_cnt;
    logic              inc_rslt_addr;
    logic              inc_weight_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rd_valid;
    logic              img_start;
    logic              img_done;

    modport master (
        input  cfg_valid, cfg_sel, cfg_data, start, num_imgs, reg_out,
        input  mem_gnt, mem_rd_valid, img_done,
        output cfg_ready, busy, done, wr_reg_sel, reg_wr_en, reg_databus, rd_reg_sel,
        output inc_img_addr, inc_img_cnt, inc_rslt_addr, inc_weight_addr,
        output mem_req, mem_we, mem_addr, img_start
    );

    modport slave (
        output cfg_valid, cfg_sel, cfg_data, start, num_imgs, reg_out,
        output mem_gnt, mem_rd_valid, img_done,
        input  cfg_ready, busy, done, wr_reg_sel, reg_wr_en, reg_databus, rd_reg_sel,
        input  inc_img_addr, inc_img_cnt, inc_rslt_addr, inc_weight_addr,
        input  mem_req, mem_we, mem_addr, img_start
    );

endinterface

// File: rtl/reg_seq_ctrl.sv
// Run sequencer: host register writes in idle, then weight fetch and a per-image
// read / compute / result-write loop driven through the external register file.
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int unsigned NUM_WEIGHT_LINES = 64,
    parameter int unsigned ADDR_W           = 28
) (
    input logic            clk,
    input logic            rst_n,
    reg_seq_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] NumWl = ADDR_W'(NUM_WEIGHT_LINES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] num_imgs_q, num_imgs_d;
    logic [ADDR_W-1:0] wl_cnt_q, wl_cnt_d;
    logic [ADDR_W-1:0] img_done_cnt_q, img_done_cnt_d;
    logic              img_start_q, img_start_d;

    logic              cfg_ready, busy, done, reg_wr_en, mem_req, mem_we;
    logic [1:0]        wr_reg_sel, rd_reg_sel;
    logic [ADDR_W-1:0] reg_databus;
    logic              inc_img_addr, inc_img_cnt, inc_rslt_addr, inc_weight_addr;

    always_comb begin
        state_d         = state_q;
        num_imgs_d      = num_imgs_q;
        wl_cnt_d        = wl_cnt_q;
        img_done_cnt_d  = img_done_cnt_q;
        img_start_d     = 1'b0;
        cfg_ready       = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        reg_wr_en       = 1'b0;
        wr_reg_sel      = SEL_IMG_ADDR;
        reg_databus     = '0;
        rd_reg_sel      = SEL_IMG_ADDR;
        inc_img_addr    = 1'b0;
        inc_img_cnt     = 1'b0;
        inc_rslt_addr   = 1'b0;
        inc_weight_addr = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                cfg_ready = 1'b1;
                // A config write wins over start in the same cycle.
                if (bus.cfg_valid) begin
                    reg_wr_en   = 1'b1;
                    wr_reg_sel  = bus.cfg_sel;
                    reg_databus = bus.cfg_data;
                end else if (bus.start) begin
                    if (bus.num_imgs == '0) begin
                        state_d = StDone;
                    end else begin
                        num_imgs_d     = bus.num_imgs;
                        wl_cnt_d       = '0;
                        img_done_cnt_d = '0;
                        state_d        = StWReq;
                    end
                end
            end
            StWReq: begin
                rd_reg_sel = SEL_WEIGHT_ADDR;
                mem_req    = 1'b1;
                if (bus.mem_gnt) begin
                    inc_weight_addr = 1'b1;
                    state_d         = StWWait;
                end
            end
            StWWait: begin
                rd_reg_sel = SEL_WEIGHT_ADDR;
                if (bus.mem_rd_valid) begin
                    wl_cnt_d = wl_cnt_q + 1'b1;
                    state_d  = (wl_cnt_d == NumWl) ? StIReq : StWReq;
                end
            end
            StIReq: begin
                mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    inc_img_addr = 1'b1;
                    state_d      = StIWait;
                end
            end
            StIWait: begin
                if (bus.mem_rd_valid) begin
                    img_start_d = 1'b1;
                    state_d     = StCompute;
                end
            end
            StCompute: begin
                if (bus.img_done) begin
                    state_d = StRReq;
                end
            end
            StRReq: begin
                rd_reg_sel = SEL_RSLT_ADDR;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                if (bus.mem_gnt) begin
                    inc_rslt_addr  = 1'b1;
                    inc_img_cnt    = 1'b1;
                    img_done_cnt_d = img_done_cnt_q + 1'b1;
                    state_d        = StCheck;
                end
            end
            StCheck: begin
                state_d = (img_done_cnt_q == num_imgs_q) ? StDone : StIReq;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            num_imgs_q     <= '0;
            wl_cnt_q       <= '0;
            img_done_cnt_q <= '0;
            img_start_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_imgs_q     <= num_imgs_d;
            wl_cnt_q       <= wl_cnt_d;
            img_done_cnt_q <= img_done_cnt_d;
            img_start_q    <= img_start_d;
        end
    end

    // Upper register-file read bits are not part of the address.
    logic unused_reg_out;
    assign unused_reg_out = ^bus.reg_out[31:ADDR_W];

    assign bus.cfg_ready       = cfg_ready;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.reg_wr_en       = reg_wr_en;
    assign bus.wr_reg_sel      = wr_reg_sel;
    assign bus.reg_databus     = reg_databus;
    assign bus.rd_reg_sel      = rd_reg_sel;
    assign bus.inc_img_addr    = inc_img_addr;
    assign bus.inc_img_cnt     = inc_img_cnt;
    assign bus.inc_rslt_addr   = inc_rslt_addr;
    assign bus.inc_weight_addr = inc_weight_addr;
    assign bus.mem_req         = mem_req;
    assign bus.mem_we          = mem_we;
    assign bus.mem_addr        = bus.reg_out[ADDR_W-1:0];
    assign bus.img_start       = img_start_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl with a register-file model, a memory responder with random grant
// delay and a compute-engine model.
module tb_reg_seq_ctrl;
    import reg_seq_pkg::*;

    typedef struct packed {
        logic        we;
        logic [27:0] addr;
    } mem_op_t;

    typedef struct {
        logic        cfg_valid;
        logic [1:0]  cfg_sel;
        logic [27:0] cfg_data;
        logic        exp_wr_en;
        logic [1:0]  exp_wr_sel;
        logic [27:0] exp_databus;
        logic        exp_ready;
    } cfg_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_seq_ctrl_if #(.ADDR_W(28)) bus ();

    reg_seq_ctrl #(
        .NUM_WEIGHT_LINES(4),
        .ADDR_W          (28)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Register file model
    logic [27:0] rf [4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (bus.reg_wr_en) begin
            rf[bus.wr_reg_sel] <= bus.reg_databus;
        end else begin
            if (bus.inc_img_addr)    rf[0] <= rf[0] + 28'd1;
            if (bus.inc_img_cnt)     rf[1] <= rf[1] + 28'd1;
            if (bus.inc_rslt_addr)   rf[2] <= rf[2] + 28'd1;
            if (bus.inc_weight_addr) rf[3] <= rf[3] + 28'd1;
        end
    end
    assign bus.reg_out = {4'b0, rf[bus.rd_reg_sel]};

    // Knobs set by the main sequence
    bit hold_rreq = 0;
    bit spur_mode = 0;
    bit hold_compute = 0;

    mem_op_t log_q[$];
    mem_op_t exp_q[$];
    int stab_err = 0;
    int spur_cnt = 0;

    // Memory and compute environment, driven on the falling edge
    initial begin : env
        int gnt_cnt, rv_wait, comp_wait;
        bit req_seen, spur_pend;
        logic [27:0] req_addr;
        logic req_we;
        gnt_cnt = 0; rv_wait = -1; comp_wait = -1; req_seen = 0; spur_pend = 0;
        req_addr = '0; req_we = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rd_valid = 1'b0; bus.img_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            bus.mem_rd_valid = 1'b0;
            bus.img_done = 1'b0;
            if (!rst_n) begin
                req_seen = 0; rv_wait = -1; comp_wait = -1; spur_pend = 0;
            end else begin
                if (rv_wait == 0) bus.mem_rd_valid = 1'b1;
                if (rv_wait >= 0) rv_wait--;
                if (bus.img_start && !hold_compute) comp_wait = int'($urandom_range(0, 2));
                if (spur_pend || comp_wait == 0) bus.img_done = 1'b1;
                if (spur_pend) spur_cnt++;
                spur_pend = 0;
                if (comp_wait >= 0) comp_wait--;
                if (bus.mem_req) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        req_addr = bus.mem_addr;
                        req_we   = bus.mem_we;
                        gnt_cnt  = (hold_rreq && bus.mem_we) ? 10 : int'($urandom_range(0, 3));
                    end else if (bus.mem_addr !== req_addr || bus.mem_we !== req_we) begin
                        stab_err++;
                    end
                    if (gnt_cnt == 0) begin
                        bus.mem_gnt = 1'b1;
                        req_seen = 0;
                        log_q.push_back({req_we, req_addr});
                        if (!req_we) begin
                            if (spur_mode && bus.rd_reg_sel == SEL_IMG_ADDR) begin
                                rv_wait = 2;
                                spur_pend = 1;
                            end else begin
                                rv_wait = int'($urandom_range(0, 2));
                            end
                        end
                    end else begin
                        gnt_cnt--;
                    end
                end
            end
        end
    end

    // Monitor, sampled mid-low-phase after the environment has driven
    int done_cnt = 0;
    int rslt_inc_cnt = 0;
    int rreq_cycles = 0;
    int inv_err = 0;
    always begin
        int incs;
        @(negedge clk);
        #2;
        if (rst_n) begin
            incs = $countones({bus.inc_img_addr, bus.inc_img_cnt, bus.inc_rslt_addr,
                               bus.inc_weight_addr});
            if (bus.done) done_cnt++;
            if (bus.inc_rslt_addr) rslt_inc_cnt++;
            if (bus.mem_req && bus.mem_we) rreq_cycles++;
            if (bus.reg_wr_en && (bus.busy || incs != 0)) inv_err++;
            if (incs > 1 && !(incs == 2 && bus.inc_rslt_addr && bus.inc_img_cnt)) inv_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_log();
        int n;
        check("log_len", log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("mem_op[%0d]", i), 32'(log_q[i]), 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_run(input logic [27:0] wt, input logic [27:0] img,
                              input logic [27:0] rs, input int nimg);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, wt + 28'(i)});
        for (int i = 0; i < nimg; i++) begin
            exp_q.push_back({1'b0, img + 28'(i)});
            exp_q.push_back({1'b1, rs + 28'(i)});
        end
    endtask

    task automatic check_regs(input logic [27:0] img, input logic [27:0] cnt,
                              input logic [27:0] rs, input logic [27:0] wt);
        check("rf_img_addr", rf[0], img);
        check("rf_img_cnt", rf[1], cnt);
        check("rf_rslt_addr", rf[2], rs);
        check("rf_weight_addr", rf[3], wt);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [27:0] data);
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic kick(input logic [27:0] n);
        @(negedge clk);
        bus.start = 1'b1; bus.num_imgs = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt - base, 1);
        check("busy_after_done", bus.busy, 1'b0);
    endtask

    cfg_vec_t cfg_vecs[6];

    initial begin : main
        int base, n;
        cfg_vecs[0] = '{1'b1, 2'd0, 28'h100, 1'b1, 2'd0, 28'h100, 1'b1};
        cfg_vecs[1] = '{1'b1, 2'd2, 28'h800, 1'b1, 2'd2, 28'h800, 1'b1};
        cfg_vecs[2] = '{1'b1, 2'd3, 28'h040, 1'b1, 2'd3, 28'h040, 1'b1};
        cfg_vecs[3] = '{1'b1, 2'd1, 28'h000, 1'b1, 2'd1, 28'h000, 1'b1};
        cfg_vecs[4] = '{1'b0, 2'd2, 28'hABC, 1'b0, 2'd0, 28'h000, 1'b1};
        cfg_vecs[5] = '{1'b1, 2'd1, 28'h000, 1'b1, 2'd1, 28'h000, 1'b1};

        bus.cfg_valid = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.num_imgs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cfg_ready", bus.cfg_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_reg_wr_en", bus.reg_wr_en, 1'b0);
        check("rst_img_start", bus.img_start, 1'b0);
        check("rst_rd_sel", bus.rd_reg_sel, 2'd0);

        // 1: config pass-through
        foreach (cfg_vecs[i]) begin
            @(negedge clk);
            bus.cfg_valid = cfg_vecs[i].cfg_valid;
            bus.cfg_sel   = cfg_vecs[i].cfg_sel;
            bus.cfg_data  = cfg_vecs[i].cfg_data;
            #1;
            check($sformatf("cfg%0d_wr_en", i), bus.reg_wr_en, cfg_vecs[i].exp_wr_en);
            check($sformatf("cfg%0d_wr_sel", i), bus.wr_reg_sel, cfg_vecs[i].exp_wr_sel);
            check($sformatf("cfg%0d_databus", i), bus.reg_databus, cfg_vecs[i].exp_databus);
            check($sformatf("cfg%0d_ready", i), bus.cfg_ready, cfg_vecs[i].exp_ready);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check_regs(28'h100, 28'h0, 28'h800, 28'h40);
        check("reg_out_idle", bus.reg_out, 32'h100);

        // 2: two-image run
        base = done_cnt;
        expect_run(28'h40, 28'h100, 28'h800, 2);
        kick(28'd2);
        wait_done(base);
        check_log();
        check_regs(28'h102, 28'h2, 28'h802, 28'h44);

        // 3: zero images goes straight to done
        base = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.num_imgs = '0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("zero_done", bus.done, 1'b1);
        check("zero_busy", bus.busy, 1'b1);
        check("zero_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        #1;
        check("zero_done_low", bus.done, 1'b0);
        check("zero_busy_low", bus.busy, 1'b0);
        check("zero_cfg_ready", bus.cfg_ready, 1'b1);
        @(negedge clk);
        check("zero_done_cnt", done_cnt - base, 1);
        check_log();

        // 4: result write held off for 10 cycles
        hold_rreq = 1;
        base = done_cnt;
        n = rreq_cycles;
        rslt_inc_cnt = rslt_inc_cnt;
        begin
            int rb;
            rb = rslt_inc_cnt;
            expect_run(28'h44, 28'h102, 28'h802, 1);
            kick(28'd1);
            wait_done(base);
            check("rreq_hold_cycles", rreq_cycles - n, 11);
            check("rslt_inc_once", rslt_inc_cnt - rb, 1);
        end
        hold_rreq = 0;
        check_log();
        check_regs(28'h103, 28'h3, 28'h803, 28'h48);

        // 5: cfg/start while busy, spurious img_done in I_WAIT
        spur_mode = 1;
        base = done_cnt;
        expect_run(28'h48, 28'h103, 28'h803, 1);
        kick(28'd1);
        n = 0;
        while (!(bus.mem_req && bus.rd_reg_sel == SEL_IMG_ADDR) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_img_req", 32'(n < 500), 1);
        bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd3; bus.cfg_data = 28'h5555;
        bus.start = 1'b1; bus.num_imgs = 28'd7;
        repeat (3) begin
            #1;
            check("busy_wr_en", bus.reg_wr_en, 1'b0);
            check("busy_cfg_ready", bus.cfg_ready, 1'b0);
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        wait_done(base);
        spur_mode = 0;
        check("spurious_done_sent", spur_cnt, 1);
        check_log();
        check_regs(28'h104, 28'h4, 28'h804, 28'h4C);

        // 6: reset while computing, then a clean run
        hold_compute = 1;
        kick(28'd1);
        n = 0;
        while (!bus.img_start && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_compute", 32'(n < 500), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_cfg_ready", bus.cfg_ready, 1'b1);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_mem_req", bus.mem_req, 1'b0);
        check("arst_img_start", bus.img_start, 1'b0);
        @(posedge clk);
        #1;
        check("arst_done", bus.done, 1'b0);
        check("arst_rd_sel", bus.rd_reg_sel, 2'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 28'h4C + 28'(i)});
        exp_q.push_back({1'b0, 28'h104});
        check_log();
        hold_compute = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_write(SEL_IMG_ADDR, 28'h200);
        cfg_write(SEL_RSLT_ADDR, 28'h900);
        cfg_write(SEL_WEIGHT_ADDR, 28'h10);
        base = done_cnt;
        expect_run(28'h10, 28'h200, 28'h900, 1);
        kick(28'd1);
        wait_done(base);
        check_log();
        check_regs(28'h201, 28'h1, 28'h901, 28'h14);

        check("req_stability", stab_err, 0);
        check("invariants", inv_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
